// File: rtl/rv32_fetch_buffer.sv
`default_nettype none
// ============================================================================
// rv32_fetch_buffer: PC, one-deep in-flight tracker and DEPTH-entry queue
// between the instruction ROM and ID. Optional bypass: FB_BYPASS_EN. Rev 1.0
// ============================================================================
module rv32_fetch_buffer #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            fetch_req_o,
  output logic [XLEN-1:0] fetch_pc_o,
  input  logic [XLEN-1:0] rom_inst_i,
  output logic            fb_valid_o,
  output logic [XLEN-1:0] fb_inst_o,
  output logic [XLEN-1:0] fb_pc_o,
  input  logic            id_ready_i,
  input  logic            id_jump_en_i,
  input  logic [XLEN-1:0] id_jump_pc_i,
  input  logic            ex_redirect_i,
  input  logic [XLEN-1:0] ex_redirect_pc_i
);

  localparam int              PTR_W   = $clog2(DEPTH);
  localparam int              CNT_W   = PTR_W + 1;
  localparam logic [CNT_W:0]  DEPTH_C = DEPTH[CNT_W:0];
  localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);

  logic [XLEN-1:0]  pc;
  logic [XLEN-1:0]  pc_q;
  logic             req_q;
  logic             drop_q;
  logic [CNT_W-1:0] count;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [XLEN-1:0]  q_inst [DEPTH];
  logic [XLEN-1:0]  q_pc   [DEPTH];

  logic             redir;
  logic [XLEN-1:0]  target;
  logic [CNT_W:0]   inflight;
  logic             space;
  logic             resp;
  logic             q_nonempty;
  logic             q_pop;
  logic             q_wr;

  assign redir      = ex_redirect_i | id_jump_en_i;
  assign target     = ex_redirect_i ? ex_redirect_pc_i : id_jump_pc_i;
  // Credit is taken from registered state only, so a pop never feeds fetch_req_o.
  assign inflight   = {1'b0, count} + {{CNT_W{1'b0}}, req_q};
  assign space      = inflight < DEPTH_C;
  assign fetch_req_o = space & ~redir;
  assign fetch_pc_o = pc;

  assign resp       = req_q & ~drop_q & ~redir;
  assign q_nonempty = (count != '0);
  assign q_pop      = q_nonempty & id_ready_i;

`ifdef FB_BYPASS_EN
  logic bypass;
  assign bypass = resp & ~q_nonempty;
  assign q_wr   = resp & ~(bypass & id_ready_i);
`else
  assign q_wr   = resp;
`endif

  always_comb begin
    fb_valid_o = 1'b0;
    fb_inst_o  = NOP;
    fb_pc_o    = '0;
    if (q_nonempty) begin
      fb_valid_o = 1'b1;
      fb_inst_o  = q_inst[rd_ptr];
      fb_pc_o    = q_pc[rd_ptr];
    end
`ifdef FB_BYPASS_EN
    else if (bypass) begin
      fb_valid_o = 1'b1;
      fb_inst_o  = rom_inst_i;
      fb_pc_o    = pc_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= RESET_PC;
      pc_q   <= '0;
      req_q  <= 1'b0;
      drop_q <= 1'b0;
      count  <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else if (redir) begin
      pc     <= target;
      req_q  <= 1'b0;
      drop_q <= 1'b1;
      count  <= '0;
      rd_ptr <= wr_ptr;
    end else begin
      if (fetch_req_o) begin
        pc     <= pc + XLEN'(4);
        pc_q   <= pc;
        req_q  <= 1'b1;
        drop_q <= 1'b0;
      end else begin
        req_q  <= 1'b0;
      end
      if (q_wr) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (q_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + {{(CNT_W-1){1'b0}}, q_wr} - {{(CNT_W-1){1'b0}}, q_pop};
    end
  end

  // Queue storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (q_wr) begin
      q_inst[wr_ptr] <= rom_inst_i;
      q_pc[wr_ptr]   <= pc_q;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32_fetch_buffer.sv
`default_nettype none
// Directed bench for rv32_fetch_buffer: ROM model plus expected-PC scoreboard.
module tb_rv32_fetch_buffer;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
`ifdef FB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            fetch_req;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rom_inst = '0;
  logic            fb_valid;
  logic [XLEN-1:0] fb_inst;
  logic [XLEN-1:0] fb_pc;
  logic            id_ready = 1'b1;
  logic            id_jump_en = 1'b0;
  logic [XLEN-1:0] id_jump_pc = '0;
  logic            ex_redirect = 1'b0;
  logic [XLEN-1:0] ex_redirect_pc = '0;

  int total = 0;
  int bad   = 0;
  int pops  = 0;
  logic [31:0] exp_q [$];

  rv32_fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fetch_req_o      (fetch_req),
    .fetch_pc_o       (fetch_pc),
    .rom_inst_i       (rom_inst),
    .fb_valid_o       (fb_valid),
    .fb_inst_o        (fb_inst),
    .fb_pc_o          (fb_pc),
    .id_ready_i       (id_ready),
    .id_jump_en_i     (id_jump_en),
    .id_jump_pc_i     (id_jump_pc),
    .ex_redirect_i    (ex_redirect),
    .ex_redirect_pc_i (ex_redirect_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_fn(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[15:0]};
  endfunction

  // Synchronous ROM: data for an accepted request is presented next cycle.
  always @(posedge clk) begin
    if (fetch_req) rom_inst <= rom_fn(fetch_pc);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Sample at the falling edge; every accepted head is scored against the model.
  task automatic mon();
    logic [31:0] e;
    @(negedge clk);
    if (fb_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_valid", {31'd0, fb_valid}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", fb_pc, e);
        check("sb_inst", fb_inst, rom_fn(e));
        pops++;
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      mon();
      adv();
    end
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_fetch_pc", fetch_pc, 32'h0);
    check("rst_fb_valid", {31'd0, fb_valid}, 32'd0);
    check("rst_fb_inst", fb_inst, 32'h13);
    check("rst_fb_pc", fb_pc, 32'h0);
    adv();
    rst_n = 1'b1;
    push_stream(32'h0, 64);
    pops = 0;

    // Sequential fetch from reset with ID always ready
    for (int k = 0; k <= 10; k++) begin
      mon();
      check("seq_fetch_req", {31'd0, fetch_req}, 32'd1);
      check("seq_fetch_pc", fetch_pc, 32'(4 * k));
      check("seq_fb_valid", {31'd0, fb_valid}, {31'd0, (k >= LAT)});
      adv();
    end
    check("seq_pops", 32'(pops), 32'(11 - LAT));

    // Fill from reset with ID stalled
    rst_n = 1'b0;
    id_ready = 1'b0;
    adv();
    rst_n = 1'b1;
    push_stream(32'h0, 64);
    pops = 0;
    for (int k = 0; k < 4; k++) begin
      mon();
      check("fill_fetch_req", {31'd0, fetch_req}, 32'd1);
      check("fill_fetch_pc", fetch_pc, 32'(4 * k));
      adv();
    end
    for (int k = 4; k < 7; k++) begin
      mon();
      check("full_fetch_req", {31'd0, fetch_req}, 32'd0);
      check("full_fb_valid", {31'd0, fb_valid}, 32'd1);
      check("full_fb_pc", fb_pc, 32'h0);
      check("full_fb_inst", fb_inst, rom_fn(32'h0));
      adv();
    end
    id_ready = 1'b1;
    mon();
    check("pop_same_cycle_req", {31'd0, fetch_req}, 32'd0);
    adv();
    mon();
    check("pop_next_cycle_req", {31'd0, fetch_req}, 32'd1);
    check("pop_next_cycle_pc", fetch_pc, 32'h10);
    adv();
    cyc(6);
    check("drain_pops", 32'(pops), 32'd8);

    // Full queue, then EX redirect to 0x100
    id_ready = 1'b0;
    cyc(7);
    mon();
    check("pre_redir_full_req", {31'd0, fetch_req}, 32'd0);
    check("pre_redir_valid", {31'd0, fb_valid}, 32'd1);
    adv();
    ex_redirect = 1'b1;
    ex_redirect_pc = 32'h100;
    mon();
    check("redir_cycle_req", {31'd0, fetch_req}, 32'd0);
    adv();
    ex_redirect = 1'b0;
    push_stream(32'h100, 64);
    mon();
    check("redir_t1_valid", {31'd0, fb_valid}, 32'd0);
    check("redir_t1_req", {31'd0, fetch_req}, 32'd1);
    check("redir_t1_pc", fetch_pc, 32'h100);
    adv();
    mon();
    check("redir_t2_valid", {31'd0, fb_valid}, {31'd0, (LAT == 1)});
    adv();
    mon();
    check("redir_t3_valid", {31'd0, fb_valid}, 32'd1);
    check("redir_t3_pc", fb_pc, 32'h100);
    check("redir_t3_inst", fb_inst, rom_fn(32'h100));
    adv();
    id_ready = 1'b1;
    pops = 0;
    cyc(8);
    check("redir_drain_pops", 32'(pops), 32'd8);

    // Simultaneous EX and ID redirect while streaming: EX wins
    ex_redirect = 1'b1;
    ex_redirect_pc = 32'h200;
    id_jump_en = 1'b1;
    id_jump_pc = 32'h300;
    mon();
    check("dual_redir_req", {31'd0, fetch_req}, 32'd0);
    adv();
    ex_redirect = 1'b0;
    id_jump_en = 1'b0;
    push_stream(32'h200, 64);
    mon();
    check("dual_t1_pc", fetch_pc, 32'h200);
    check("dual_t1_req", {31'd0, fetch_req}, 32'd1);
    check("dual_t1_valid", {31'd0, fb_valid}, 32'd0);
    adv();
    pops = 0;
    cyc(10);
    check("dual_pops", 32'(pops), 32'(11 - LAT));

    // ID jump alone
    id_jump_en = 1'b1;
    id_jump_pc = 32'h400;
    mon();
    adv();
    id_jump_en = 1'b0;
    push_stream(32'h400, 64);
    mon();
    check("jump_t1_pc", fetch_pc, 32'h400);
    adv();

    // Pseudo-random back-pressure across several pointer wraps
    pops = 0;
    for (int k = 0; k < 40; k++) begin
      id_ready = 1'($urandom_range(0, 1));
      mon();
      adv();
    end
    id_ready = 1'b1;
    cyc(8);
    check("rand_min_pops", {31'd0, (pops >= 3 * DEPTH)}, 32'd1);

    // Asynchronous reset with a partly filled queue
    id_ready = 1'b0;
    cyc(2);
    mon();
    check("pre_reset_valid", {31'd0, fb_valid}, 32'd1);
    adv();
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_valid", {31'd0, fb_valid}, 32'd0);
    check("async_rst_inst", fb_inst, 32'h13);
    check("async_rst_fb_pc", fb_pc, 32'h0);
    check("async_rst_fetch_pc", fetch_pc, 32'h0);
    adv();
    rst_n = 1'b1;
    id_ready = 1'b1;
    push_stream(32'h0, 64);
    pops = 0;
    for (int k = 0; k < 10; k++) begin
      mon();
      check("restart_fetch_pc", fetch_pc, 32'(4 * k));
      adv();
    end
    check("restart_pops", 32'(pops), 32'(10 - LAT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rv32_fetch_buffer.md
# rv32_fetch_buffer

Parametrised fetch front-end for the rv32 pipeline, replacing the single-register PC/IF-ID path with a program counter, a one-deep in-flight request tracker and a DEPTH-entry instruction queue. It issues sequential fetches to the synchronous instruction ROM and absorbs decode back-pressure through a valid/ready handshake. It drops wrong-path instructions on redirects from EX (branch) and ID (jump). It sits between the ROM and the ID stage.

## Interface
- XLEN, 32: instruction and PC width.
- DEPTH, 4: queue entries; power of two, ≥2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req_o  out  1  ROM read request this cycle.
- fetch_pc_o  out  XLEN  ROM read address; the registered PC.
- rom_inst_i  in  XLEN  ROM data, valid the cycle after an accepted request.
- fb_valid_o  out  1  queue head valid to ID.
- fb_inst_o  out  XLEN  head instruction; 32'h0000_0013 (NOP) when fb_valid_o=0.
- fb_pc_o  out  XLEN  head PC; 0 when fb_valid_o=0.
- id_ready_i  in  1  ID accepts head; pop when fb_valid_o & id_ready_i.
- id_jump_en_i  in  1  ID jump redirect.
- id_jump_pc_i  in  XLEN  ID jump target.
- ex_redirect_i  in  1  EX taken-branch redirect.
- ex_redirect_pc_i  in  XLEN  EX branch target.

## Operation
- Reset values: pc=RESET_PC, queue empty (count=0, rd_ptr=wr_ptr=0), req_q=0, drop_q=0.
- Redirect: redir = ex_redirect_i | id_jump_en_i. EX has priority; target = ex_redirect_i ? ex_redirect_pc_i : id_jump_pc_i.
- Space: space = (count + req_q) < DEPTH. Uses only registered state; a same-cycle pop does not add credit.
- fetch_req_o = space & ~redir. On request: pc <= pc+4, req_q <= 1, pc_q <= pc, drop_q <= 0. With no request: req_q <= 0.
- Response: when req_q=1 and drop_q=0, {pc_q, rom_inst_i} is written at wr_ptr. Then wr_ptr increments modulo DEPTH.
- Pop: head leaves on fb_valid_o & id_ready_i; rd_ptr increments modulo DEPTH.
- Count: +1 on write, −1 on pop, unchanged on both. It never exceeds DEPTH, because the space rule guarantees this.
- Redirect cycle:
  - pc <= target.
  - Queue cleared: count=0, and rd_ptr=wr_ptr.
  - drop_q <= 1 for any request outstanding into the next cycle.
  - A response arriving in the redirect cycle is discarded.
  - A pop in the same cycle still counts as accepted by ID.
- Reset mid-operation clears everything asynchronously; in-flight data is discarded.

## Timing
- Sequential fetch: a request in cycle T returns ROM data in T+1. The entry is written at the end of T+1, and fb_valid_o rises in T+2.
- Steady state: one instruction per cycle with id_ready_i=1.
- Redirect at T:
  - no request in T;
  - target request in T+1;
  - target instruction valid at fb_valid_o in T+3 (T+2 with bypass).
- Full queue (count=DEPTH): fetch_req_o=0 until count drops. A single pop re-enables requests one cycle later.
- Outputs fb_* are a combinational read of the head entry. There is no combinational path from id_ready_i to fb_*.

## Configuration
- FB_BYPASS_EN defined: when the queue is empty and a non-dropped response arrives, rom_inst_i/pc_q drive fb_* in that same cycle with fb_valid_o=1.
  - If id_ready_i=1 the entry is consumed and not written.
  - Otherwise it is written as normal.
  - Redirect in that cycle suppresses the bypass.
- FB_BYPASS_EN undefined: the queue path is always used; empty-queue latency is one cycle longer.

## Test plan
- Reset release with id_ready_i=1, RESET_PC=0 -> fetch_pc_o 0,4,8,… on consecutive cycles; fb_pc_o=0 first valid in cycle 2 after release (cycle 1 with bypass); then one new PC per cycle.
- id_ready_i=0, DEPTH=4 -> exactly 4 entries (PCs 0,4,8,C); fetch_req_o low once count+req_q=4. Raising id_ready_i then drains 0,4,8,C in order with no duplicate or lost PC.
- Full queue, ex_redirect_i=1 with ex_redirect_pc_i=0x100 for one cycle -> fb_valid_o=0 the next cycle; the stale in-flight response is dropped; first valid fb_pc_o=0x100, fb_inst_o=ROM[0x100].
- ex_redirect_i and id_jump_en_i together (0x200 vs 0x300) -> next request address 0x200; 0x300 never fetched.
- Run ≥3·DEPTH instructions with id_ready_i toggling pseudo-randomly -> fb_pc_o strictly +4 across pointer wrap; count never exceeds DEPTH.
- rst_n asserted mid-stream with the queue half full -> fb_valid_o=0, fb_inst_o=0x13, fetch_pc_o=RESET_PC immediately; after release the fetch restarts cleanly from RESET_PC.
